// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback queue in front of the 32x32 register file
// write port. Two producers (A = ALU, B = load) push up to two entries per cycle;
// at most one entry drains per cycle. Writes to r0 are accepted and then dropped.
// Optional feature macro: WB_BYPASS_EN enables the pending-write bypass lookup.
// Without it, Hit1/Hit2 and BypData1/BypData2 are tied to zero.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [4:0]    a_reg,
    input  logic [31:0]   a_data,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_reg,
    input  logic [31:0]   b_data,
    input  logic          drain_en,
    output logic          RegWre,
    output logic [4:0]    WriteReg,
    output logic [31:0]   WriteData,
    input  logic [4:0]    ReadReg1,
    input  logic [4:0]    ReadReg2,
    output logic          Hit1,
    output logic          Hit2,
    output logic [31:0]   BypData1,
    output logic [31:0]   BypData2,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [4:0]       reg_q   [DEPTH];
    logic [4:0]       reg_d   [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [31:0]      data_d  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             a_push, b_push, pop;
    logic [PW-1:0]    b_slot;

    // Handshake readiness and status, all from the registered count only
    always_comb begin
        a_ready = (count_q < DEPTH_C);
        b_ready = (count_q < (DEPTH_C - CW'(a_valid)));
        a_push  = a_valid && a_ready && (a_reg != '0);
        b_push  = b_valid && b_ready && (b_reg != '0);
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_C);
        count   = count_q;
    end

    // Head entry presented to the register file; zeros when nothing is queued
    always_comb begin
        RegWre    = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        if (!empty) begin
            RegWre    = drain_en;
            WriteReg  = reg_q[rd_ptr_q];
            WriteData = data_q[rd_ptr_q];
        end
        pop = RegWre;
    end

    // Queue next state: pop the head, append A then B (A is older)
    always_comb begin
        reg_d    = reg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        b_slot   = a_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;

        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (a_push) begin
            reg_d[wr_ptr_q]   = a_reg;
            data_d[wr_ptr_q]  = a_data;
            valid_d[wr_ptr_q] = 1'b1;
        end
        if (b_push) begin
            reg_d[b_slot]   = b_reg;
            data_d[b_slot]  = b_data;
            valid_d[b_slot] = 1'b1;
        end

        wr_ptr_d = wr_ptr_q + PW'(a_push) + PW'(b_push);
        count_d  = count_q + CW'(a_push) + CW'(b_push) - CW'(pop);
    end

    // Control state: pointers, occupancy and per-entry valid bits
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Entry payload storage; contents are qualified by valid_q so no reset needed
    always_ff @(posedge CLK) begin
        reg_q  <= reg_d;
        data_q <= data_d;
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        Hit1     = 1'b0;
        Hit2     = 1'b0;
        BypData1 = '0;
        BypData2 = '0;
        byp_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr_q + PW'(i);
            if (valid_q[byp_idx] && (ReadReg1 != '0) && (reg_q[byp_idx] == ReadReg1)) begin
                Hit1     = 1'b1;
                BypData1 = data_q[byp_idx];
            end
            if (valid_q[byp_idx] && (ReadReg2 != '0) && (reg_q[byp_idx] == ReadReg2)) begin
                Hit2     = 1'b1;
                BypData2 = data_q[byp_idx];
            end
        end
    end
`else
    // Bypass disabled: consumers must stall on !empty before reading operands
    always_comb begin
        Hit1     = 1'b0;
        Hit2     = 1'b0;
        BypData1 = '0;
        BypData2 = '0;
    end

    logic unused_rd;
    assign unused_rd = ^{ReadReg1, ReadReg2};
`endif

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side front end for the 32x32 register file write port. It drives RegWre/WriteReg/WriteData.
- Accepts writeback requests from two producers: port A (ALU result) and port B (load data). It buffers them in an in-order FIFO and drains at most one entry per cycle into the register file.
- Provides bypass lookup so operand reads never see stale data while writes are still pending.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- CW, 3, count width = log2(DEPTH)+1

Ports:
- CLK  input  1  system clock; queue state updates on posedge
- RST  input  1  reset, asynchronous, active-low; clears all state
- a_valid  input  1  port A request valid
- a_ready  output  1  port A can accept
- a_reg  input  5  port A destination register
- a_data  input  32  port A write data
- b_valid  input  1  port B request valid
- b_ready  output  1  port B can accept
- b_reg  input  5  port B destination register
- b_data  input  32  port B write data
- drain_en  input  1  1 = head may be written this cycle
- RegWre  output  1  register-file write enable
- WriteReg  output  5  register-file write address
- WriteData  output  32  register-file write data
- ReadReg1  input  5  rs lookup address
- ReadReg2  input  5  rt lookup address
- Hit1  output  1  pending write to ReadReg1 exists
- Hit2  output  1  pending write to ReadReg2 exists
- BypData1  output  32  youngest pending data for ReadReg1
- BypData2  output  32  youngest pending data for ReadReg2
- count  output  CW  occupied entries
- empty  output  1  count == 0
- full  output  1  count == DEPTH

Behaviour:
- Reset (RST=0, async): rd/wr pointers = 0, count = 0, all entry valid bits = 0.
  - Outputs during reset: empty=1, full=0, RegWre=0, WriteReg=0, WriteData=0, Hit1/Hit2=0, BypData=0.
  - Entry data contents need not be cleared.
- Ready (combinational; uses registered count only, ignores same-cycle pop):
  - a_ready = (count < DEPTH)
  - b_ready = (count < DEPTH - (a_valid ? 1 : 0))
- Handshake: transfer on posedge when valid && ready. Producers hold valid/reg/data stable until accepted.
- Register-0 filter: an accepted request with reg == 0 completes the handshake, but is not enqueued and consumes no slot.
- Ordering:
  - Same-cycle A and B: A is enqueued first (older), B second.
  - Up to 2 pushes per cycle.
- Drain:
  - RegWre = !empty && drain_en; WriteReg/WriteData = head entry, driven combinationally.
  - When !empty, WriteReg/WriteData show the head even if drain_en=0; when empty they are 0.
  - The register file captures on negedge CLK. The head is popped at the following posedge if RegWre=1.
- Count update: count_next = count + pushes(0..2) - pop(0/1). Simultaneous push and pop at full is legal; the pop does not raise ready in that cycle.
- Latency: a request accepted at posedge k into an empty queue with drain_en=1 gives RegWre=1 in cycle k and is written at the negedge inside cycle k. Throughput is 1 write/cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. full/empty come from count, never from pointer compare.
- Bypass (combinational):
  - HitN = 1 iff ReadRegN != 0 and some queued entry has reg == ReadRegN.
  - BypDataN = data of the youngest such entry; 0 if no hit.
  - The head entry counts as pending until popped.
- Same register queued twice: drained in order, so the register file ends with the younger value.
- drain_en=0 holds the queue. Pushes continue until full, then ready drops.
- Reset mid-operation discards all pending entries. No register-file write occurs after RST falls.

Optional Feature:
- WB_BYPASS_EN
  - Defined: bypass lookup as specified.
  - Undefined: Hit1=Hit2=0 and BypData1=BypData2=0 constantly; no comparator logic. The pipeline must then stall on !empty before operand reads.

Test Plan:
- Reset: RST=0 mid-stream with 3 entries queued -> count=0, empty=1, RegWre=0 immediately (async); no write after release until a new push.
- Dual push: A=(r5,0x11111111) and B=(r6,0x22222222) in same cycle, drain_en=1 -> cycle 1 writes r5=0x11111111, cycle 2 writes r6=0x22222222; count 2->1->0.
- Full/backpressure (DEPTH=4, drain_en=0): push 4 entries -> full=1, a_ready=0. Then a_valid=0 with count=3 -> b_ready=1. Then a_valid=1 with count=3 -> b_ready=0.
- Reg-0 filter: A=(r0,0xDEADBEEF) accepted -> count unchanged, RegWre stays 0.
- Bypass: queue (r7,0xA), then (r7,0xB), drain_en=0, ReadReg1=7 -> Hit1=1, BypData1=0xB. With ReadReg2=0 -> Hit2=0.
- Wrap: 10 push/pop pairs through DEPTH=4 with drain toggling -> write sequence to the register file exactly matches push order; count never exceeds 4.
